preimage_scanner: RTL and testbench

PREIMAGE_SCANNER -- requirements
Module: preimage_scanner

---
 rtl/preimage_scanner_pkg.sv | 18 +
 rtl/preimage_scanner_fwd_func.sv | 22 ++
 rtl/preimage_scanner.sv | 109 ++++++++++
 tb/tb_preimage_scanner.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preimage_scanner_pkg.sv
// Shared constants and state encoding for the preimage scanner.
// Every module that needs the index, target or count widths imports these definitions from here.
package preimage_scanner_pkg;

  localparam int IDX_W = 4;
  localparam int TGT_W = 2;
  localparam int CNT_W = 5;

  localparam logic [IDX_W-1:0] IDX_LAST = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/preimage_scanner_fwd_func.sv
// Forward function c = f(a, b), built as purely combinational gates.
// The inputs map as p=a[1], q=a[0], r=b[1], s=b[0].
module fwd_func (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] c
);

  logic w_p;
  logic w_q;
  logic w_r;
  logic w_s;

  assign w_p = a[1];
  assign w_q = a[0];
  assign w_r = b[1];
  assign w_s = b[0];

  assign c[1] = (~w_p & w_r & w_s) | (~w_p & w_q & w_r) | (w_p & ~w_r);
  assign c[0] = (w_q | w_r) & (w_p | w_q | w_s) & (~w_p | w_r);

endmodule

// File: rtl/preimage_scanner.sv
// Walks all 16 {a,b} pairs in ascending order and presents each pair whose f(a,b)
// equals the latched target over a valid/ready style match port.
//
// match handshake: match_valid rises with match_a/match_b; all three hold until the
// first cycle out_ready=1 is sampled, at which edge the match is consumed.
module preimage_scanner
  import preimage_scanner_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [TGT_W-1:0] target,
  input  logic             out_ready,
  output logic             busy,
  output logic             match_valid,
  output logic [1:0]       match_a,
  output logic [1:0]       match_b,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [TGT_W-1:0] r_target;
  logic             r_busy;
  logic             r_valid;
  logic [1:0]       r_a;
  logic [1:0]       r_b;
  logic             r_done;
  logic [CNT_W-1:0] r_count;

  logic [1:0]       w_c;
  logic             w_hit;

  fwd_func u_fwd (
    .a (r_idx[3:2]),
    .b (r_idx[1:0]),
    .c (w_c)
  );

  assign w_hit = (w_c == r_target);

  // done is registered off the DONE state, so it appears on the cycle after DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_target <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_done   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_target <= target;
            r_idx    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_hit) begin
            r_a     <= r_idx[3:2];
            r_b     <= r_idx[1:0];
            r_valid <= 1'b1;
            r_count <= r_count + CNT_W'(1);
            r_state <= ST_EMIT;
          end else if (r_idx == IDX_LAST) begin
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            if (r_idx == IDX_LAST) begin
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_SCAN;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign match_valid = r_valid;
  assign match_a     = r_a;
  assign match_b     = r_b;
  assign done        = r_done;
  assign count       = r_count;

endmodule

// File: tb/tb_preimage_scanner.sv
// Bench for preimage_scanner: forward-function truth table, directed scans with
// stalls, ignored restarts and reset aborts, then randomized scans against a reference model.
module tb_preimage_scanner;
  import preimage_scanner_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [TGT_W-1:0] target;
  logic             out_ready;
  logic             busy;
  logic             match_valid;
  logic [1:0]       match_a;
  logic [1:0]       match_b;
  logic             done;
  logic [CNT_W-1:0] count;

  logic [1:0] tv_a;
  logic [1:0] tv_b;
  logic [1:0] tv_c;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
  } vec_t;

  vec_t tbl[16];

  always #5 clk = ~clk;

  preimage_scanner dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .target      (target),
    .out_ready   (out_ready),
    .busy        (busy),
    .match_valid (match_valid),
    .match_a     (match_a),
    .match_b     (match_b),
    .done        (done),
    .count       (count)
  );

  fwd_func u_fwd_tb (
    .a (tv_a),
    .b (tv_b),
    .c (tv_c)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Reference: the forward function written directly from its boolean definition.
  function automatic int model_f(input int a, input int b);
    bit p, q, r, s, c1, c0;
    p  = a[1];
    q  = a[0];
    r  = b[1];
    s  = b[0];
    c1 = (!p && r && s) || (!p && q && r) || (p && !r);
    c0 = (q || r) && (p || q || s) && (!p || r);
    return (c1 ? 2 : 0) + (c0 ? 1 : 0);
  endfunction

  task automatic build_exp(input int tgt);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (model_f(i / 4, i % 4) == tgt) exp_q.push_back(4'(i));
    end
  endtask

  // mode 0: out_ready always 1; mode 1: stall 5 cycles at first match; mode 2: random.
  // poke_at: cycle at which start is re-pulsed and target replaced by poke_tgt.
  task automatic run_scan(input int tgt, input int mode, input int poke_at,
                          input int poke_tgt, input bit check_lat);
    int n;
    int done_k;
    int done_cnt;
    int stall;
    bit first_seen;
    bit prev_stalled;
    logic [1:0] pa, pb;
    logic [3:0] e;
    build_exp(tgt);
    n = exp_q.size();
    done_k = -1;
    done_cnt = 0;
    stall = 0;
    first_seen = 0;
    prev_stalled = 0;
    pa = '0;
    pb = '0;
    @(negedge clk);
    target    = 2'(tgt);
    start     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == poke_at) begin
        start  = 1'b1;
        target = 2'(poke_tgt);
      end
      if (prev_stalled) begin
        check("hold_valid", match_valid, 1);
        check("hold_a", match_a, pa);
        check("hold_b", match_b, pb);
      end
      prev_stalled = 0;
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          if (match_valid && !first_seen) begin
            first_seen = 1;
            stall = 5;
          end
          if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (match_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("extra_match");
          end else begin
            e = exp_q.pop_front();
            check("match_a", match_a, e[3:2]);
            check("match_b", match_b, e[1:0]);
          end
        end else begin
          prev_stalled = 1;
          pa = match_a;
          pb = match_b;
        end
      end
      if (k == 1) check("busy_in_scan", busy, 1);
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          check("count_at_done", count, n);
          check("busy_at_done", busy, 0);
          check("missing_matches", exp_q.size(), 0);
          if (check_lat) check("done_latency", k, 17 + n);
        end
      end
      if (done_k >= 0 && k == done_k + 2) begin
        check("done_pulses", done_cnt, 1);
        check("busy_after_done", busy, 0);
        break;
      end
    end
    if (done_k < 0) fail_now("done_timeout");
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("count_hold_idle", count, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    int hist[4];
    int exp_hist[4];
    logic [1:0] c_tab[16];
    bit seen;
    int dn;
    int t;

    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    target    = '0;
    tv_a      = '0;
    tv_b      = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", match_valid, 0);
    check("rst_a", match_a, 0);
    check("rst_b", match_b, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    rst = 1'b0;

    // T6: forward function truth table (hand-derived), per-target preimage counts
    c_tab = '{2'd0, 2'd0, 2'd0, 2'd3,
              2'd1, 2'd1, 2'd3, 2'd3,
              2'd2, 2'd2, 2'd1, 2'd1,
              2'd2, 2'd2, 2'd1, 2'd1};
    for (int i = 0; i < 16; i++) begin
      tbl[i].a = 2'(i / 4);
      tbl[i].b = 2'(i % 4);
      tbl[i].c = c_tab[i];
    end
    exp_hist = '{3, 6, 4, 3};
    for (int i = 0; i < 4; i++) hist[i] = 0;
    for (int i = 0; i < 16; i++) begin
      tv_a = tbl[i].a;
      tv_b = tbl[i].b;
      #1;
      check($sformatf("fwd_func_%0d", i), tv_c, tbl[i].c);
      hist[tv_c]++;
    end
    for (int i = 0; i < 4; i++) check($sformatf("preimages_t%0d", i), hist[i], exp_hist[i]);

    // T1..T4
    run_scan(1, 0, -1, 0, 1);
    run_scan(0, 0, 19, 0, 1);
    run_scan(2, 1, -1, 0, 0);
    run_scan(3, 0, 5, 0, 1);

    // T5: reset while a match is being held
    @(negedge clk);
    target    = 2'd1;
    start     = 1'b1;
    out_ready = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (match_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now("t5_no_emit");
    rst       = 1'b1;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_valid", match_valid, 0);
    check("t5_a", match_a, 0);
    check("t5_b", match_b, 0);
    check("t5_done", done, 0);
    check("t5_count", count, 0);
    rst   = 1'b0;
    start = 1'b0;
    dn = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("t5_no_done_pulse", dn, 0);
    check("t5_idle_busy", busy, 0);
    run_scan(1, 0, -1, 0, 1);

    // randomized scans with random back-pressure and ignored mid-scan restarts
    for (int r = 0; r < 8; r++) begin
      t = $urandom_range(0, 3);
      run_scan(t, 2, $urandom_range(0, 10), $urandom_range(0, 3), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
